// File: rtl/ts_qos_selector.sv
// Four-channel MPEG-2 TS monitor and QoS selector: per-channel sync lock, presence
// timeout and saturating error counts drive a packet-aligned output switch.
//
// state     | meaning
// ST_HUNT   | searching for a sync byte
// ST_VERIFY | one sync seen, waiting for the next at the packet boundary
// ST_LOCK   | aligned; every packet boundary must carry the sync byte
module ts_qos_selector #(
    parameter int         PKT_LEN   = 188,
    parameter logic [7:0] SYNC_BYTE = 8'h47,
    parameter int         TIMEOUT   = 4096
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        valid1,
    input  logic        valid2,
    input  logic        valid3,
    input  logic        valid4,
    input  logic [7:0]  ts_data1,
    input  logic [7:0]  ts_data2,
    input  logic [7:0]  ts_data3,
    input  logic [7:0]  ts_data4,
    input  logic        mm_write_en,
    input  logic        mm_read_en,
    input  logic [7:0]  mm_addr,
    input  logic [31:0] mm_wdata,
    output logic [31:0] mm_rdata,
    output logic        clk_out,
    output logic        valid_out,
    output logic        syn_out,
    output logic [7:0]  ts_data_out
);

    localparam int IDX_W = $clog2(PKT_LEN);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;
    localparam logic [31:0] CFG_RST  = {20'd50000, 8'b11100100, 2'b00, 1'b0, 1'b1};

    logic [3:0]       vld;
    logic [7:0]       dat [4];
    logic [1:0]       st_q [4], st_d [4];
    logic [IDX_W-1:0] idx_q [4], idx_d [4];
    logic [TMO_W-1:0] tmo_q [4], tmo_d [4];
    logic [7:0]       err_q [4], err_d [4];
    logic [19:0]      hcnt_q [4], hcnt_d [4];
    logic [3:0]       pres_q, pres_d;
    logic [3:0]       pos0, syn_c, sw_ok, healthy, long_h, locked;
    logic [1:0]       active_q, active_d, target, ch, best_ch, rev_ch;
    logic [2:0]       act_rank;
    logic             best_ok, rev_ok;
    logic [31:0]      cfg_q, rdata_q, rd_mux;
    logic             vo_q, so_q;
    logic [7:0]       do_q;

    logic        fb_en, man_en;
    logic [1:0]  man_ch;
    logic [7:0]  prio;
    logic [19:0] reset_timer;

    assign fb_en       = cfg_q[0];
    assign man_en      = cfg_q[1];
    assign man_ch      = cfg_q[3:2];
    assign prio        = cfg_q[11:4];
    assign reset_timer = cfg_q[31:12];

    assign vld    = {valid4, valid3, valid2, valid1};
    assign dat[0] = ts_data1;
    assign dat[1] = ts_data2;
    assign dat[2] = ts_data3;
    assign dat[3] = ts_data4;

    // idx_q holds the index of the last accepted byte, so pos0 flags the next byte as index 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_d[i]    = st_q[i];
            idx_d[i]   = idx_q[i];
            tmo_d[i]   = tmo_q[i];
            err_d[i]   = err_q[i];
            pres_d[i]  = pres_q[i];
            pos0[i]    = (idx_q[i] == IDX_W'(PKT_LEN - 1));
            locked[i]  = (st_q[i] == ST_LOCK);
            syn_c[i]   = vld[i] && (dat[i] == SYNC_BYTE) && pos0[i] && (st_q[i] != ST_HUNT);
            sw_ok[i]   = vld[i] && (dat[i] == SYNC_BYTE) && (pos0[i] || (st_q[i] == ST_HUNT));
            healthy[i] = pres_q[i] && locked[i];
            long_h[i]  = healthy[i] && (hcnt_q[i] == 20'd0);
            if (!healthy[i])
                hcnt_d[i] = reset_timer;
            else if (hcnt_q[i] != 20'd0)
                hcnt_d[i] = hcnt_q[i] - 20'd1;
            else
                hcnt_d[i] = hcnt_q[i];

            if (vld[i]) begin
                tmo_d[i]  = TMO_W'(TIMEOUT - 1);
                pres_d[i] = 1'b1;
                idx_d[i]  = pos0[i] ? '0 : idx_q[i] + 1'b1;
                case (st_q[i])
                    ST_HUNT: begin
                        if (dat[i] == SYNC_BYTE) begin
                            st_d[i]  = ST_VERIFY;
                            idx_d[i] = '0;
                        end
                    end
                    ST_VERIFY: begin
                        if (pos0[i])
                            st_d[i] = (dat[i] == SYNC_BYTE) ? ST_LOCK : ST_HUNT;
                    end
                    ST_LOCK: begin
                        if (pos0[i] && (dat[i] != SYNC_BYTE)) begin
                            st_d[i]  = ST_HUNT;
                            err_d[i] = (err_q[i] == 8'hFF) ? err_q[i] : err_q[i] + 8'd1;
                        end
                    end
                    default: st_d[i] = ST_HUNT;
                endcase
            end else if (tmo_q[i] != '0) begin
                tmo_d[i] = tmo_q[i] - 1'b1;
            end else if (pres_q[i]) begin
                pres_d[i] = 1'b0;
                st_d[i]   = ST_HUNT;
                err_d[i]  = (err_q[i] == 8'hFF) ? err_q[i] : err_q[i] + 8'd1;
            end
        end
    end

    // Scanning from lowest to highest priority lets the highest-priority match win.
    always_comb begin
        ch       = 2'd0;
        act_rank = 3'd4;
        best_ok  = 1'b0;
        best_ch  = active_q;
        rev_ok   = 1'b0;
        rev_ch   = active_q;
        for (int r = 3; r >= 0; r--) begin
            if (prio[2*r +: 2] == active_q)
                act_rank = 3'(r);
        end
        for (int r = 3; r >= 0; r--) begin
            ch = prio[2*r +: 2];
            if (healthy[ch]) begin
                best_ok = 1'b1;
                best_ch = ch;
            end
            if (long_h[ch] && (3'(r) < act_rank)) begin
                rev_ok = 1'b1;
                rev_ch = ch;
            end
        end
        target = active_q;
        if (man_en)
            target = man_ch;
        else if (!healthy[active_q]) begin
            if (best_ok)
                target = best_ch;
        end else if (fb_en && rev_ok)
            target = rev_ch;
        active_d = ((target != active_q) && sw_ok[target]) ? target : active_q;
    end

    always_comb begin
        case (mm_addr)
            8'h00:   rd_mux = cfg_q;
            8'h01:   rd_mux = {22'd0, locked, pres_q, active_q};
            8'h02:   rd_mux = {err_q[3], err_q[2], err_q[1], err_q[0]};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= ST_HUNT;
                idx_q[i]  <= '0;
                tmo_q[i]  <= '0;
                err_q[i]  <= '0;
                hcnt_q[i] <= CFG_RST[31:12];
            end
            pres_q   <= '0;
            active_q <= '0;
            cfg_q    <= CFG_RST;
            rdata_q  <= '0;
            vo_q     <= 1'b0;
            so_q     <= 1'b0;
            do_q     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= st_d[i];
                idx_q[i]  <= idx_d[i];
                tmo_q[i]  <= tmo_d[i];
                err_q[i]  <= err_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
            pres_q   <= pres_d;
            active_q <= active_d;
            if (mm_write_en && (mm_addr == 8'h00))
                cfg_q <= mm_wdata;
            if (mm_read_en)
                rdata_q <= rd_mux;
            vo_q <= vld[active_d];
            so_q <= syn_c[active_d];
            do_q <= dat[active_d];
        end
    end

    assign clk_out     = rclk;
    assign mm_rdata    = rdata_q;
    assign valid_out   = vo_q;
    assign syn_out     = so_q;
    assign ts_data_out = do_q;

endmodule

// File: tb/tb_ts_qos_selector.sv
// Bench for ts_qos_selector: random-gap TS streams checked each cycle against a
// packet-position reference model, plus directed register checks for each scenario.
module tb_ts_qos_selector;

    localparam int         L  = 16;
    localparam int         TO = 64;
    localparam logic [7:0] SB = 8'h47;

    logic        rclk = 1'b0;
    logic        rst = 1'b1;
    logic        valid1 = 0, valid2 = 0, valid3 = 0, valid4 = 0;
    logic [7:0]  ts_data1 = 0, ts_data2 = 0, ts_data3 = 0, ts_data4 = 0;
    logic        mm_write_en = 0, mm_read_en = 0;
    logic [7:0]  mm_addr = 0;
    logic [31:0] mm_wdata = 0;
    logic [31:0] mm_rdata;
    logic        clk_out, valid_out, syn_out;
    logic [7:0]  ts_data_out;

    always #5 rclk = ~rclk;

    ts_qos_selector #(.PKT_LEN(L), .SYNC_BYTE(SB), .TIMEOUT(TO)) dut (
        .rclk(rclk), .rst(rst),
        .valid1(valid1), .valid2(valid2), .valid3(valid3), .valid4(valid4),
        .ts_data1(ts_data1), .ts_data2(ts_data2), .ts_data3(ts_data3), .ts_data4(ts_data4),
        .mm_write_en(mm_write_en), .mm_read_en(mm_read_en), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .clk_out(clk_out),
        .valid_out(valid_out), .syn_out(syn_out), .ts_data_out(ts_data_out)
    );

    int vectors = 0;
    int miscompares = 0;

    int   gpos[4], gpkt[4];
    bit   stop[4], corrupt[4];
    bit   burst1 = 0;
    logic [3:0] v_in;
    logic [7:0] d_in[4];

    // Model: m_pos = index of last byte in the current packet, -1 while hunting.
    int          m_pos[4], m_syncs[4], m_idle[4], m_hfor[4], m_err[4];
    bit          m_pres[4];
    int          m_active;
    logic [31:0] m_cfg, m_rdata;
    logic        m_vo, m_so;
    logic [7:0]  m_do;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_pos[c] = -1; m_syncs[c] = 0; m_idle[c] = 0; m_hfor[c] = 0;
            m_err[c] = 0;  m_pres[c] = 0;
        end
        m_active = 0;
        m_cfg    = 32'h0C350E41;
        m_rdata  = 0;
        m_vo = 0; m_so = 0; m_do = 0;
    endtask

    task automatic model_step();
        bit h[4], lg[4], sok[4], sy[4];
        int ca[4];
        int rank_a, tgt, np;
        logic [31:0] s;
        for (int c = 0; c < 4; c++) begin
            h[c]      = m_pres[c] && m_pos[c] >= 0 && m_syncs[c] >= 2;
            m_hfor[c] = h[c] ? m_hfor[c] + 1 : 0;
            lg[c]     = h[c] && (m_hfor[c] > int'(m_cfg[31:12]));
            np        = (m_pos[c] + 1) % L;
            sy[c]     = v_in[c] && d_in[c] == SB && m_pos[c] >= 0 && np == 0;
            sok[c]    = v_in[c] && d_in[c] == SB && (m_pos[c] < 0 || np == 0);
        end
        for (int r = 0; r < 4; r++) ca[r] = int'(m_cfg[4 + 2*r +: 2]);
        rank_a = 4;
        for (int r = 0; r < 4; r++) if (rank_a == 4 && ca[r] == m_active) rank_a = r;
        tgt = m_active;
        if (m_cfg[1]) tgt = int'(m_cfg[3:2]);
        else if (!h[m_active]) begin
            for (int r = 0; r < 4; r++) if (h[ca[r]]) begin tgt = ca[r]; break; end
        end else if (m_cfg[0]) begin
            for (int r = 0; r < rank_a; r++) if (lg[ca[r]]) begin tgt = ca[r]; break; end
        end
        if (mm_read_en) begin
            s = 0;
            if (mm_addr == 8'h00) s = m_cfg;
            else if (mm_addr == 8'h01) begin
                s[1:0] = 2'(m_active);
                for (int c = 0; c < 4; c++) begin
                    s[2 + c] = m_pres[c];
                    s[6 + c] = (m_pos[c] >= 0 && m_syncs[c] >= 2);
                end
            end else if (mm_addr == 8'h02)
                for (int c = 0; c < 4; c++) s[8*c +: 8] = 8'(m_err[c]);
            m_rdata = s;
        end
        if (tgt != m_active && sok[tgt]) m_active = tgt;
        m_vo = v_in[m_active];
        m_do = d_in[m_active];
        m_so = sy[m_active];
        for (int c = 0; c < 4; c++) begin
            if (v_in[c]) begin
                m_idle[c] = 0;
                m_pres[c] = 1;
                if (m_pos[c] < 0) begin
                    if (d_in[c] == SB) begin m_pos[c] = 0; m_syncs[c] = 1; end
                end else begin
                    np = (m_pos[c] + 1) % L;
                    m_pos[c] = np;
                    if (np == 0) begin
                        if (d_in[c] == SB) m_syncs[c]++;
                        else begin
                            if (m_syncs[c] >= 2 && m_err[c] < 255) m_err[c]++;
                            m_pos[c] = -1; m_syncs[c] = 0;
                        end
                    end
                end
            end else begin
                m_idle[c]++;
                if (m_pres[c] && m_idle[c] >= TO) begin
                    m_pres[c] = 0;
                    if (m_err[c] < 255) m_err[c]++;
                    m_pos[c] = -1; m_syncs[c] = 0;
                end
            end
        end
        if (mm_write_en && mm_addr == 8'h00) m_cfg = mm_wdata;
    endtask

    task automatic gen_inputs();
        logic [7:0] b;
        for (int c = 0; c < 4; c++) begin
            v_in[c] = !stop[c] && ($urandom_range(0, 7) != 0);
            b = 8'($urandom_range(0, 255));
            if (b == SB) b = 8'h00;
            if (v_in[c]) begin
                if (gpos[c] == 0) begin
                    b = SB;
                    if (corrupt[c] || (burst1 && c == 1 && gpkt[c] % 3 == 2)) begin
                        b = 8'h46;
                        corrupt[c] = 0;
                    end
                end
                gpos[c] = (gpos[c] + 1) % L;
                if (gpos[c] == 0) gpkt[c]++;
            end
            d_in[c] = b;
        end
        valid1 = v_in[0]; valid2 = v_in[1]; valid3 = v_in[2]; valid4 = v_in[3];
        ts_data1 = d_in[0]; ts_data2 = d_in[1]; ts_data3 = d_in[2]; ts_data4 = d_in[3];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        gen_inputs();
        @(posedge rclk);
        #1;
        if (rst) model_reset(); else model_step();
        vectors++;
        assert (valid_out === m_vo && syn_out === m_so && ts_data_out === m_do
                && mm_rdata === m_rdata && clk_out === 1'b1) else begin
            miscompares++;
            $error("FAIL outputs got v=%b s=%b d=%h rd=%h ck=%b exp v=%b s=%b d=%h rd=%h ck=1",
                   valid_out, syn_out, ts_data_out, mm_rdata, clk_out, m_vo, m_so, m_do, m_rdata);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic mm_rd(input logic [7:0] a, output logic [31:0] d);
        mm_read_en = 1; mm_addr = a;
        cycle();
        mm_read_en = 0;
        d = mm_rdata;
    endtask

    task automatic mm_wr(input logic [31:0] w);
        mm_write_en = 1; mm_addr = 8'h00; mm_wdata = w;
        cycle();
        mm_write_en = 0;
    endtask

    logic [31:0] rd;

    initial begin
        for (int c = 0; c < 4; c++) begin gpos[c] = 0; gpkt[c] = 0; stop[c] = 0; corrupt[c] = 0; end
        model_reset();
        rst = 1;
        run(3);
        check("reset_valid_out", {31'd0, valid_out}, 32'd0);
        rst = 0;

        mm_rd(8'h00, rd); check("cfg_reset", rd, 32'h0C350E41);
        mm_rd(8'h01, rd); check("active_reset", {30'd0, rd[1:0]}, 32'd0);

        // simultaneous read and write of config returns the old value
        mm_read_en = 1;
        mm_wr(32'h000C8E41);
        mm_read_en = 0;
        check("rw_old_value", mm_rdata, 32'h0C350E41);
        mm_rd(8'h00, rd); check("cfg_written", rd, 32'h000C8E41);

        run(400);
        mm_rd(8'h02, rd); check("errs_clean", rd, 32'd0);
        mm_rd(8'h01, rd); check("status_clean", rd, 32'h000003FC);

        corrupt[0] = 1;
        run(150);
        mm_rd(8'h02, rd); check("ch0_err1", {24'd0, rd[7:0]}, 32'd1);
        mm_rd(8'h01, rd); check("switch_to_ch1", {30'd0, rd[1:0]}, 32'd1);
        run(300);
        mm_rd(8'h01, rd); check("revert_to_ch0", {30'd0, rd[1:0]}, 32'd0);

        mm_wr(32'h000C8E40);
        corrupt[0] = 1;
        run(600);
        mm_rd(8'h01, rd); check("no_fallback_stay_ch1", {30'd0, rd[1:0]}, 32'd1);
        mm_rd(8'h02, rd); check("ch0_err2", {24'd0, rd[7:0]}, 32'd2);

        mm_wr(32'h000C8E4A);
        run(60);
        mm_rd(8'h01, rd); check("manual_ch2", {30'd0, rd[1:0]}, 32'd2);
        corrupt[0] = 1; corrupt[1] = 1;
        run(100);
        mm_rd(8'h01, rd); check("manual_hold_ch2", {30'd0, rd[1:0]}, 32'd2);

        stop[3] = 1;
        run(80);
        mm_rd(8'h01, rd); check("ch3_absent", {31'd0, rd[5]}, 32'd0);
        mm_rd(8'h02, rd); check("ch3_timeout_err", {24'd0, rd[31:24]}, 32'd1);
        stop[3] = 0;

        burst1 = 1;
        run(16000);
        burst1 = 0;
        mm_rd(8'h02, rd); check("ch1_saturate", {24'd0, rd[15:8]}, 32'd255);

        mm_wr(32'h000C8391);
        run(400);
        mm_rd(8'h01, rd); check("priority_ch1", {30'd0, rd[1:0]}, 32'd1);

        run(7);
        rst = 1;
        cycle();
        check("midpkt_reset_valid", {31'd0, valid_out}, 32'd0);
        rst = 0;
        mm_rd(8'h01, rd); check("active_after_rst", {30'd0, rd[1:0]}, 32'd0);
        mm_rd(8'h00, rd); check("cfg_after_rst", rd, 32'h0C350E41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
